// File: rtl/wb_port_sequencer.sv
// wb_port_sequencer: serialises one or two writeback results onto the single
// register-file write port and tracks outstanding writes per register.
module wb_port_sequencer #(
  parameter int NREGS  = 16,
  parameter int IDX_W  = 4,
  parameter int DATA_W = 64,
  parameter int CNT_W  = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wb_valid,
  output logic              wb_ready,
  input  logic              wb_we0,
  input  logic [IDX_W-1:0]  wb_idx0,
  input  logic [DATA_W-1:0] wb_data0,
  input  logic              wb_we1,
  input  logic [IDX_W-1:0]  wb_idx1,
  input  logic [DATA_W-1:0] wb_data1,
  output logic              rf_we,
  output logic [IDX_W-1:0]  rf_waddr,
  output logic [DATA_W-1:0] rf_wdata,
  output logic              wb_done,
  input  logic              sb_set,
  input  logic [IDX_W-1:0]  sb_set_idx,
  output logic [NREGS-1:0]  busy_mask,
  output logic              sb_overflow
);

  typedef enum logic [1:0] {IDLE, WR0, WR1, NOP} state_e;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_e            state_q;
  logic              we1_q;
  logic [IDX_W-1:0]  idx1_q;
  logic [DATA_W-1:0] data1_q;
  logic              rf_we_q;
  logic [IDX_W-1:0]  rf_waddr_q;
  logic [DATA_W-1:0] rf_wdata_q;
  logic              wb_done_q;

  logic [CNT_W-1:0]  cnt_q [NREGS];
  logic [CNT_W-1:0]  cnt_d [NREGS];
  logic              ovf_q;
  logic              ovf_d;
  logic [NREGS-1:0]  inc_v;
  logic [NREGS-1:0]  dec_v;

  assign wb_ready    = (state_q == IDLE);
  assign rf_we       = rf_we_q;
  assign rf_waddr    = rf_waddr_q;
  assign rf_wdata    = rf_wdata_q;
  assign wb_done     = wb_done_q;
  assign sb_overflow = ovf_q;

  // Outputs are computed for the state being entered, so they are
  // registered and line up with that state's cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      we1_q      <= 1'b0;
      idx1_q     <= '0;
      data1_q    <= '0;
      rf_we_q    <= 1'b0;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
      wb_done_q  <= 1'b0;
    end else begin
      rf_we_q   <= 1'b0;
      wb_done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (wb_valid) begin
            we1_q   <= wb_we1;
            idx1_q  <= wb_idx1;
            data1_q <= wb_data1;
            if (wb_we0) begin
              state_q    <= WR0;
              rf_we_q    <= 1'b1;
              rf_waddr_q <= wb_idx0;
              rf_wdata_q <= wb_data0;
              wb_done_q  <= ~wb_we1;
            end else if (wb_we1) begin
              state_q    <= WR1;
              rf_we_q    <= 1'b1;
              rf_waddr_q <= wb_idx1;
              rf_wdata_q <= wb_data1;
              wb_done_q  <= 1'b1;
            end else begin
              state_q   <= NOP;
              wb_done_q <= 1'b1;
            end
          end
        end
        WR0: begin
          if (we1_q) begin
            state_q    <= WR1;
            rf_we_q    <= 1'b1;
            rf_waddr_q <= idx1_q;
            rf_wdata_q <= data1_q;
            wb_done_q  <= 1'b1;
          end else begin
            state_q <= IDLE;
          end
        end
        WR1:     state_q <= IDLE;
        NOP:     state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  always_comb begin
    inc_v = '0;
    dec_v = '0;
    for (int i = 0; i < NREGS; i++) begin
      inc_v[i] = sb_set && (sb_set_idx == IDX_W'(i));
      dec_v[i] = rf_we_q && (rf_waddr_q == IDX_W'(i));
    end
  end

  // A simultaneous set and clear on one register cancel out.
  always_comb begin
    ovf_d = ovf_q;
    for (int i = 0; i < NREGS; i++) begin
      cnt_d[i] = cnt_q[i];
      if (inc_v[i] && !dec_v[i]) begin
        if (cnt_q[i] == CNT_MAX) ovf_d = 1'b1;
        else cnt_d[i] = cnt_q[i] + CNT_ONE;
      end else if (dec_v[i] && !inc_v[i]) begin
        if (cnt_q[i] != '0) cnt_d[i] = cnt_q[i] - CNT_ONE;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ovf_q <= 1'b0;
      for (int i = 0; i < NREGS; i++) cnt_q[i] <= '0;
    end else begin
      ovf_q <= ovf_d;
      for (int i = 0; i < NREGS; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  always_comb begin
    busy_mask = '0;
    for (int i = 0; i < NREGS; i++) busy_mask[i] = (cnt_q[i] != '0);
  end

endmodule
